// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Purpose  : Load/store controller in front of a byte-addressable data memory
//            (combinational read, synchronous write). Accepts one request at
//            a time, checks alignment and range, drives the memory port for
//            exactly one cycle, extends load data and returns a response.
// Ports    : clk, rst_n (sync, active-low)
//            req_*   : request handshake + write/size/unsigned/addr/wdata
//            resp_*  : response handshake + rdata/err
//            mem_*   : memory address/write_data/write/read/size/read_data
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
  parameter int MEM_BYTES = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_read_data
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  logic [1:0]  state;
  logic        lat_write;
  logic        lat_unsigned;
  logic [32:0] nbytes_m1;
  logic [32:0] last_byte;
  logic [1:0]  err_next;
  logic [31:0] load_ext;

  // Error detection on the incoming request. The last byte touched is
  // computed 33 bits wide so an address near 0xFFFFFFFF cannot wrap back
  // into the legal range.
  always_comb begin
    case (req_size)
      2'b00:   nbytes_m1 = 33'd0;
      2'b01:   nbytes_m1 = 33'd1;
      default: nbytes_m1 = 33'd3;
    endcase
    last_byte   = {1'b0, req_addr} + nbytes_m1;
    err_next[1] = (last_byte >= MEM_LIMIT);
    err_next[0] = (req_size == 2'b11) ||
                  ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Extension uses only the low byte/half of the raw memory word; any
  // extension the memory itself applies is overridden here.
  always_comb begin
    case (mem_size)
      2'b00:   load_ext = lat_unsigned ? {24'h0, mem_read_data[7:0]}
                                       : {{24{mem_read_data[7]}}, mem_read_data[7:0]};
      2'b01:   load_ext = lat_unsigned ? {16'h0, mem_read_data[15:0]}
                                       : {{16{mem_read_data[15]}}, mem_read_data[15:0]};
      default: load_ext = mem_read_data;
    endcase
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  // Strobes are decoded from state so they are high for the whole ACCESS
  // cycle, including one in which reset is being asserted.
  assign mem_read   = (state == ST_ACCESS) && !lat_write;
  assign mem_write  = (state == ST_ACCESS) &&  lat_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      lat_write      <= 1'b0;
      lat_unsigned   <= 1'b0;
      mem_address    <= 32'h0;
      mem_write_data <= 32'h0;
      mem_size       <= 2'b00;
      resp_rdata     <= 32'h0;
      resp_err       <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            lat_write      <= req_write;
            lat_unsigned   <= req_unsigned;
            mem_address    <= req_addr;
            mem_write_data <= req_wdata;
            mem_size       <= req_size;
            resp_rdata     <= 32'h0;
            resp_err       <= err_next;
            // Errored requests skip the memory entirely.
            state          <= (|err_next) ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          resp_rdata <= lat_write ? 32'h0 : load_ext;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
